// File: rtl/mem32_pkg.sv
// mem32_pkg: shared types and helpers for the mem32 byte/half/cell aligner.
//   size_t    : access size encoding carried on the core's sz port
//   state_t   : sequencer states of mem32_aligner
//   bytes()   : number of bytes touched by an access size
//   lane_mask(): 8-bit byte-lane mask spanning two adjacent words
package mem32_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_CELL = 2'd2,
        SZ_RSV  = 2'd3
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_A0    = 3'd1,
        ST_D0    = 3'd2,
        ST_A1    = 3'd3,
        ST_D1    = 3'd4,
        ST_ALIGN = 3'd5,
        ST_ACK   = 3'd6
    } state_t;

    function automatic logic [2:0] bytes(input size_t sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_CELL: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Bits [3:0] select lanes of word w, bits [7:4] lanes of word w+1.
    function automatic logic [7:0] lane_mask(input size_t sz, input logic [1:0] off);
        logic [7:0] base;
        case (sz)
            SZ_BYTE: base = 8'h01;
            SZ_HALF: base = 8'h03;
            SZ_CELL: base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/mb32_io.sv
// mb32_io: word bus between a master and the 32-bit x 32K SPRAM bank.
//   clk  : bus clock
//   ai   : word address (master -> SPRAM)
//   vi   : write data (master -> SPRAM)
//   we   : write enable, one cycle per written word
//   bmsk : per-byte write mask
//   vo   : read data, valid one cycle after the address edge (SPRAM -> master)
interface mb32_io #(
    parameter int WW = 15
) (
    input logic clk
);
    logic [WW-1:0] ai;
    logic [31:0]   vi;
    logic [31:0]   vo;
    logic          we;
    logic [3:0]    bmsk;

    modport master (input clk, input vo, output ai, output vi, output we, output bmsk);
    modport slave  (input clk, input ai, input vi, input we, input bmsk, output vo);
endinterface

// File: rtl/mem32_lane.sv
// mem32_lane: combinational data steering for mem32_aligner.
//   Store side: st_sz/st_off/st_data -> st_lo/st_hi (data for word w / w+1),
//               m_lo/m_hi (byte masks), split (access crosses a word).
//   Fetch side: ld_sz/ld_off/ld_lo/ld_hi -> ld_data (right-justified,
//               zero-extended result).
module mem32_lane
    import mem32_pkg::*;
(
    input  size_t       st_sz,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_lo,
    output logic [31:0] st_hi,
    output logic [3:0]  m_lo,
    output logic [3:0]  m_hi,
    output logic        split,
    input  size_t       ld_sz,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_lo,
    input  logic [31:0] ld_hi,
    output logic [31:0] ld_data
);
    logic [63:0] st_sh;
    logic [63:0] ld_sh;
    logic [7:0]  msk;

    always_comb begin
        st_sh   = {32'b0, st_data} << {st_off, 3'b000};
        msk     = lane_mask(st_sz, st_off);
        st_lo   = st_sh[31:0];
        st_hi   = st_sh[63:32];
        m_lo    = msk[3:0];
        m_hi    = msk[7:4];
        split   = ({1'b0, st_off} + bytes(st_sz)) > 3'd4;

        ld_sh   = {ld_hi, ld_lo} >> {ld_off, 3'b000};
        case (ld_sz)
            SZ_BYTE: ld_data = {24'b0, ld_sh[7:0]};
            SZ_HALF: ld_data = {16'b0, ld_sh[15:0]};
            SZ_CELL: ld_data = ld_sh[31:0];
            default: ld_data = 32'b0;
        endcase
    end
endmodule

// File: rtl/mem32_aligner.sv
// mem32_aligner: byte-addressed load/store front end for the 32-bit SPRAM.
// Turns byte/half/cell accesses (misaligned allowed) into one or two word
// accesses with byte masks; fetch data is captured and right-aligned.
//   clk, rst           : clock, synchronous active-high reset
//   req/we/sz/addr/wdata: request (sampled only while idle)
//   rdata/ack/busy/err : completion (rdata held until the next ack)
//   b32_if             : mb32_io master port to the SPRAM
// Build option MEM32_MISALIGN_TRAP_EN: word-crossing requests are trapped
// (err=1, no bus access) instead of being split over two words.
module mem32_aligner
    import mem32_pkg::*;
#(
    parameter int AW = 17,
    parameter int WW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    sz,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          ack,
    output logic          busy,
    output logic          err,
    mb32_io.master        b32_if
);
    state_t        state_q, state_d;
    logic          ack_q, ack_d, busy_q, busy_d, err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [WW-1:0] ai_q, ai_d;
    logic [31:0]   vi_q, vi_d;
    logic          bwe_q, bwe_d;
    logic [3:0]    bmsk_q, bmsk_d;
    // latched request
    logic          rwe_q, rwe_d, rsplit_q, rsplit_d;
    size_t         rsz_q, rsz_d;
    logic [1:0]    roff_q, roff_d;
    logic [31:0]   sthi_q, sthi_d;
    logic [3:0]    mhi_q, mhi_d;
    // captured fetch words
    logic [31:0]   lo_q, lo_d, hi_q, hi_d;

    logic [31:0]   st_lo, st_hi, ld_data;
    logic [3:0]    m_lo, m_hi;
    logic          split;

    // Store side decodes the raw request so the first bus word can be
    // registered on the acceptance edge; fetch side uses the latched copy.
    mem32_lane u_lane (
        .st_sz   (size_t'(sz)),
        .st_off  (addr[1:0]),
        .st_data (wdata),
        .st_lo   (st_lo),
        .st_hi   (st_hi),
        .m_lo    (m_lo),
        .m_hi    (m_hi),
        .split   (split),
        .ld_sz   (rsz_q),
        .ld_off  (roff_q),
        .ld_lo   (lo_q),
        .ld_hi   (hi_q),
        .ld_data (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        busy_d   = busy_q;
        rdata_d  = rdata_q;
        ai_d     = ai_q;
        vi_d     = vi_q;
        bwe_d    = 1'b0;
        bmsk_d   = 4'b0;
        rwe_d    = rwe_q;
        rsz_d    = rsz_q;
        roff_d   = roff_q;
        rsplit_d = rsplit_q;
        sthi_d   = sthi_q;
        mhi_d    = mhi_q;
        lo_d     = lo_q;
        hi_d     = hi_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    busy_d   = 1'b1;
                    rwe_d    = we;
                    rsz_d    = size_t'(sz);
                    roff_d   = addr[1:0];
                    rsplit_d = split;
                    sthi_d   = st_hi;
                    mhi_d    = m_hi;
                    if (size_t'(sz) == SZ_RSV) begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'b0;
                    end
`ifdef MEM32_MISALIGN_TRAP_EN
                    else if (split) begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end
`endif
                    else begin
                        state_d = ST_A0;
                        ai_d    = addr[AW-1:2];
                        bwe_d   = we;
                        bmsk_d  = we ? m_lo : 4'b0;
                        vi_d    = we ? st_lo : 32'b0;
                    end
                end
            end
            ST_A0: begin
                if (!rwe_q) begin
                    state_d = ST_D0;            // ai held: SPRAM mux decodes it
                end
`ifndef MEM32_MISALIGN_TRAP_EN
                else if (rsplit_q) begin
                    state_d = ST_A1;
                    ai_d    = ai_q + WW'(1);    // wraps at top of the bank
                    bwe_d   = 1'b1;
                    bmsk_d  = mhi_q;
                    vi_d    = sthi_q;
                end
`endif
                else begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                end
            end
            ST_D0: begin
                lo_d = b32_if.vo;
`ifndef MEM32_MISALIGN_TRAP_EN
                if (rsplit_q) begin
                    state_d = ST_A1;
                    ai_d    = ai_q + WW'(1);
                end else
`endif
                    state_d = ST_ALIGN;
            end
`ifndef MEM32_MISALIGN_TRAP_EN
            ST_A1: begin
                if (rwe_q) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                end else begin
                    state_d = ST_D1;
                end
            end
            ST_D1: begin
                hi_d    = b32_if.vo;
                state_d = ST_ALIGN;
            end
`endif
            ST_ALIGN: begin
                rdata_d = ld_data;
                state_d = ST_ACK;
                ack_d   = 1'b1;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'b0;
            ai_q     <= '0;
            vi_q     <= 32'b0;
            bwe_q    <= 1'b0;
            bmsk_q   <= 4'b0;
            rwe_q    <= 1'b0;
            rsz_q    <= SZ_BYTE;
            roff_q   <= 2'b0;
            rsplit_q <= 1'b0;
            sthi_q   <= 32'b0;
            mhi_q    <= 4'b0;
            lo_q     <= 32'b0;
            hi_q     <= 32'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            ai_q     <= ai_d;
            vi_q     <= vi_d;
            bwe_q    <= bwe_d;
            bmsk_q   <= bmsk_d;
            rwe_q    <= rwe_d;
            rsz_q    <= rsz_d;
            roff_q   <= roff_d;
            rsplit_q <= rsplit_d;
            sthi_q   <= sthi_d;
            mhi_q    <= mhi_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
        end
    end

    assign rdata       = rdata_q;
    assign ack         = ack_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign b32_if.ai   = ai_q;
    assign b32_if.vi   = vi_q;
    assign b32_if.we   = bwe_q;
    assign b32_if.bmsk = bmsk_q;
endmodule

// File: doc/mem32_aligner.md
Name: mem32_aligner

Overview:
- Byte-addressed load/store front end placed directly upstream of the 32-bit x 32K single-port SPRAM bank.
- Drives that bank through the mb32_io master modport.
- Converts eForth core byte, half and cell accesses, including misaligned ones, into word accesses with per-byte write masks.
- Split accesses are sequenced over two words; read data is captured and aligned before it is returned to the core.

Parameters:
- AW, 17, byte-address width (32K words x 4 bytes)
- WW, 15, word-address width driven on b32_if.ai (AW-2)

Ports:
- clk  input  1  system clock (also b32_if.clk)
- rst  input  1  synchronous active-high reset
- req  input  1  request strobe; sampled only when busy=0
- we  input  1  1=store, 0=fetch
- sz  input  2  0=byte, 1=half, 2=cell, 3=reserved
- addr  input  AW  byte address, little-endian
- wdata  input  32  store data, right-justified
- rdata  output  32  fetch result, zero-extended, held until next ack
- ack  output  1  one-cycle completion pulse
- busy  output  1  high from acceptance until the cycle ack is high (inclusive)
- err  output  1  misalign trap flag, valid with ack
- b32_if  mb32_io.master  -  bus to SPRAM (ai, vi, vo, we, bmsk)

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; ack=0, busy=0, err=0, rdata=0; bus outputs we=0, bmsk=0, ai=0, vi=0. Reset mid-operation abandons the access; any write already clocked into the SPRAM stays.
- Bus outputs are registered.
- SPRAM read data appears one cycle after the address edge. Its output mux decodes the current ai, so ai must be held through the data cycle.
- Span: n = addr[1:0] + bytes(sz); the access splits when n > 4.
- Lane mask: m = bytemask(sz) << addr[1:0] (8 bits). First word uses m[3:0]; second word (w+1) uses m[7:4].
- Store data is shifted left by addr[1:0]*8 across 64 bits; the low and high halves feed the two words.
- Word index w = addr[AW-1:2]. w+1 wraps modulo 2^WW, so 0x7FFF+1 goes to 0x0000.
- States:
  - IDLE: on req & ~busy, latch request and go to A0; busy=1.
  - A0: drive ai=w and vi/bmsk (bmsk=m[3:0] when storing; 0 when fetching), plus we.
    - Aligned store: next state ACK.
    - Split store: next state A1.
    - Fetch: next state D0.
  - D0: ai held; capture vo into lo buffer. Split: next state A1; otherwise ALIGN.
  - A1: drive ai=w+1. Store: we with m[7:4], next state ACK. Fetch: next state D1.
  - D1: capture vo into hi buffer; next state ALIGN.
  - ALIGN: rdata = ({hi,lo} >> addr[1:0]*8) masked to sz; next state ACK.
  - ACK: ack=1 for exactly one cycle, we=0, bmsk=0; next state IDLE. busy falls the following cycle.
- Latency from the req edge to the ack-high cycle:
  - aligned store: 2
  - split store: 3
  - aligned fetch: 4
  - split fetch: 6
- we is high for exactly one cycle per written word. Bytes outside the mask are never modified.
- sz=3: no bus access; ack after 1 cycle with rdata=0 and err=1.
- req while busy is ignored; no queueing.
- rst has priority over everything, including a req in the same cycle.

Optional Feature:
- Macro MEM32_MISALIGN_TRAP_EN.
- Defined: any split request (n > 4) performs no bus access; ack after 1 cycle, err=1, rdata unchanged. States A1/D1 are not built.
- Undefined: splits execute as above; err=1 only for sz=3.

Decomposition:
- Package mem32_pkg:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_CELL, SZ_RSV)
  - state_t enum
  - function bytes(sz)
  - function lane_mask(sz, off) returning 8 bits
- Sub-module mem32_lane: combinational store shift/mask and fetch right-shift/zero-extend. Kept separate so it can be tested exhaustively.

Test Plan:
- Preload word 5 = 0x44332211. Fetch cell @0x14 -> ack on cycle 4, rdata=0x44332211, err=0.
- Store byte 0xAB @0x16 -> bmsk=0100 with one we pulse. Refetch cell @0x14 -> 0x44AB2211.
- Split store cell 0xDDCCBBAA @0x17, then fetch cell @0x17:
  - store: word5 bmsk=1000, word6 bmsk=0111
  - fetch: rdata=0xDDCCBBAA, acks on cycles 3 and 6
- Wrap: store half 0xBEEF @0x1FFFF -> word 0x7FFF byte3=0xEF, word 0 byte0=0xBE.
- sz=3, and (with MEM32_MISALIGN_TRAP_EN) cell @0x01 -> err=1 and ack after 1 cycle, with zero we pulses.
- Assert rst during D0 of a fetch -> next cycle IDLE, ack=0, busy=0. A new req is then accepted normally; req while busy is ignored.
